// File: rtl/jt900h_muldiv_pkg.sv
// Shared constants and types for the jt900h iterative multiply/divide unit.
package jt900h_muldiv_pkg;

   localparam logic [1:0] SEL_MUL  = 2'b00;
   localparam logic [1:0] SEL_MULS = 2'b01;
   localparam logic [1:0] SEL_DIV  = 2'b10;
   localparam logic [1:0] SEL_DIVS = 2'b11;

   localparam int W_BYTE_BIT = 0;
   localparam int W_WORD_BIT = 1;
   localparam int W_LONG_BIT = 2;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_e;

   // Width at which a negated value is truncated and zero-extended
   typedef enum logic [1:0] {FW8, FW16, FW32} fw_e;

   typedef struct packed {
      logic word;
      logic div;
      logic sgn;
      logic s0;    // operand 0 negative (signed ops only)
      logic s1;    // operand 1 negative (signed ops only)
      logic dz;
      logic covf;  // unsigned-core quotient does not fit in N bits
   } op_t;

   function automatic logic [3:0] last_bit(input logic word);
      return word ? 4'd15 : 4'd7;
   endfunction

endpackage

// File: rtl/jt900h_muldiv_if.sv
// Start/busy/done operand and result bundle of the jt900h multiply/divide unit.
interface jt900h_muldiv_if;
   logic        start;
   logic [2:0]  w;
   logic [1:0]  sel;
   logic [31:0] op0;
   logic [15:0] op1;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [31:0] dout;

   modport master (output start, w, sel, op0, op1, input busy, done, ovf, dout);
   modport slave  (input start, w, sel, op0, op1, output busy, done, ovf, dout);
endinterface

// File: rtl/jt900h_muldiv_sgnfix.sv
// Conditional two's-complement negate, truncated and zero-extended to a selected width.
module jt900h_muldiv_sgnfix
   import jt900h_muldiv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   input  fw_e          fw_i,
   output logic [W-1:0] val_o
);

   logic [W-1:0] neg_val;
   logic [W-1:0] mask;

   always_comb begin
      case (fw_i)
         FW8:     mask = W'(8'hFF);
         FW16:    mask = W'(16'hFFFF);
         default: mask = '1;
      endcase
      neg_val = neg_i ? (~val_i + W'(1)) : val_i;
      val_o   = neg_val & mask;
   end

endmodule

// File: rtl/jt900h_muldiv.sv
// Iterative MUL/MULS/DIV/DIVS unit: shift-add multiply and restoring divide, one bit per clock.
module jt900h_muldiv
   import jt900h_muldiv_pkg::*;
(
   input logic            clk,
   input logic            rst,
   jt900h_muldiv_if.slave bus
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;
   logic [31:0] dout_q, dout_d;
   op_t         op_q, op_d;
   logic [31:0] p_q, p_d;
   logic [31:0] m_q, m_d;
   logic [15:0] b_q, b_d;

   logic        in_word, in_div, in_sgn, in_s0, in_s1, in_dz, in_covf;
   fw_e         fw0, fw1;
   logic [31:0] abs0;
   logic [15:0] abs1;
   op_t         op_in;

   // w[2] or an empty w selects word, same as w[1]
   assign in_word = !bus.w[W_BYTE_BIT] &&
                    (bus.w[W_WORD_BIT] || bus.w[W_LONG_BIT] || bus.w == 3'b000);

   always_comb begin
      case (bus.sel)
         SEL_MUL:  {in_div, in_sgn} = 2'b00;
         SEL_MULS: {in_div, in_sgn} = 2'b01;
         SEL_DIV:  {in_div, in_sgn} = 2'b10;
         SEL_DIVS: {in_div, in_sgn} = 2'b11;
         default:  {in_div, in_sgn} = 2'b00;
      endcase
   end

   assign in_s0 = in_sgn & (in_div ? (in_word ? bus.op0[31] : bus.op0[15])
                                   : (in_word ? bus.op0[15] : bus.op0[7]));
   assign in_s1 = in_sgn & (in_word ? bus.op1[15] : bus.op1[7]);
   assign fw0   = in_div ? (in_word ? FW32 : FW16) : (in_word ? FW16 : FW8);
   assign fw1   = in_word ? FW16 : FW8;

   jt900h_muldiv_sgnfix #(.W(32)) u_abs0 (.val_i(bus.op0), .neg_i(in_s0), .fw_i(fw0), .val_o(abs0));
   jt900h_muldiv_sgnfix #(.W(16)) u_abs1 (.val_i(bus.op1), .neg_i(in_s1), .fw_i(fw1), .val_o(abs1));

   assign in_dz   = in_div && (abs1 == 16'd0);
   assign in_covf = in_word ? (abs0[31:16] >= abs1) : (abs0[15:8] >= abs1[7:0]);
   assign op_in   = '{word: in_word, div: in_div, sgn: in_sgn, s0: in_s0, s1: in_s1,
                      dz: in_dz, covf: in_covf};

   // Restoring divide step; byte operands are pre-scaled so the same 16-bit compare serves both widths
   logic [32:0] sh;
   logic [16:0] top;
   logic [15:0] diff;
   logic [31:0] div_nxt;

   always_comb begin
      sh      = {p_q, 1'b0};
      top     = sh[32:16];
      diff    = top[15:0] - m_q[15:0];
      div_nxt = (top >= {1'b0, m_q[15:0]}) ? {diff, sh[15:1], 1'b1} : sh[31:0];
   end

   logic [31:0] quo_u, fixa_in, fixa;
   logic [15:0] rem_u, fixr;
   logic        neg_a, sovf;
   fw_e         fw_a, fw_r;

   assign quo_u   = op_q.word ? {16'd0, p_q[15:0]} : {24'd0, p_q[7:0]};
   assign rem_u   = op_q.word ? p_q[31:16] : {8'd0, p_q[23:16]};
   assign neg_a   = op_q.s0 ^ op_q.s1;
   assign fixa_in = op_q.div ? quo_u : p_q;
   assign fw_a    = op_q.div ? (op_q.word ? FW16 : FW8) : (op_q.word ? FW32 : FW16);
   assign fw_r    = op_q.word ? FW16 : FW8;
   // A negative quotient may reach -2^(N-1); a positive one must stay below 2^(N-1)
   assign sovf    = neg_a ? (quo_u > (op_q.word ? 32'h8000 : 32'h80))
                          : (quo_u >= (op_q.word ? 32'h8000 : 32'h80));

   jt900h_muldiv_sgnfix #(.W(32)) u_fixa (.val_i(fixa_in), .neg_i(neg_a),   .fw_i(fw_a), .val_o(fixa));
   jt900h_muldiv_sgnfix #(.W(16)) u_fixr (.val_i(rem_u),   .neg_i(op_q.s0), .fw_i(fw_r), .val_o(fixr));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      dout_d  = dout_q;
      op_d    = op_q;
      p_d     = p_q;
      m_d     = m_q;
      b_d     = b_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !done_q) begin
               op_d  = op_in;
               cnt_d = last_bit(in_word);
               if (in_dz) begin
                  state_d = ST_FIX;
                  p_d     = in_word ? bus.op0 : {16'd0, bus.op0[15:0]};
               end else begin
                  state_d = ST_RUN;
                  p_d     = in_div ? (in_word ? abs0 : {8'd0, abs0[15:0], 8'd0}) : 32'd0;
                  m_d     = in_div ? {16'd0, abs1} : abs0;
                  b_d     = abs1;
               end
            end
         end
         ST_RUN: begin
            if (op_q.div) begin
               p_d = div_nxt;
            end else begin
               p_d = b_q[0] ? (p_q + m_q) : p_q;
               m_d = {m_q[30:0], 1'b0};
               b_d = {1'b0, b_q[15:1]};
            end
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (op_q.dz) begin
               ovf_d  = 1'b1;
               dout_d = p_q;
            end else if (op_q.div) begin
               ovf_d  = op_q.covf | (op_q.sgn & sovf);
               dout_d = op_q.word ? {fixr, fixa[15:0]} : {16'd0, fixr[7:0], fixa[7:0]};
            end else begin
               ovf_d  = 1'b0;
               dout_d = fixa;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dout_q  <= 32'd0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         dout_q  <= dout_d;
         op_q    <= op_d;
      end
   end

   always_ff @(posedge clk) begin
      p_q <= p_d;
      m_q <= m_d;
      b_q <= b_d;
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;
   assign bus.dout = dout_q;

endmodule
